// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage to 16-bit SRAM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_mem_ctrl_pkg;

  // Controller states; the encodings are fixed so debug probes can decode them.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Byte address that maps onto SRAM halfword 0.
  localparam int DEF_ADDR_BASE = 1024;

  // SRAM data bus width.
  localparam int SRAM_DW = 16;

  // Beat counter width; covers wait counts 0..15.
  localparam int BEAT_CW = 4;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// MEM-stage request/response bundle for the SRAM controller.
// Latency: n/a (wiring only).
// Backpressure: master holds its request fields while ready is low.
interface sram_mem_ctrl_if;

  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  // MEM stage side
  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  // Controller side
  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_mem_ctrl_beat_timer.sv
// Loadable down-counter timing one SRAM beat.
// Latency: last asserts WAIT_CYCLES cycles after load.
// Backpressure: none; free-running once loaded.
module beat_timer
  import sram_mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam logic [BEAT_CW-1:0] LOAD_VAL = BEAT_CW'(WAIT_CYCLES);

  logic [BEAT_CW-1:0] cnt;

  // Reload at the start of each beat, then count down and park at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - BEAT_CW'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM beats (optional stats: SRAM_MEM_CTRL_STATS_EN).
// Latency: request sampled at edge 0, DONE in cycle 2*(WAIT_CYCLES+1)+1, ready high only then.
// Backpressure: ready low while an access is in flight; request inputs ignored outside IDLE.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_ctrl_if.slave     mem,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic [31:0]        stat_reads,
  output logic [31:0]        stat_writes,
  output logic [31:0]        stat_stall
);

  localparam int IW = SRAM_AW - 1;

  state_t             state, state_nxt;
  logic               req;
  logic               beat_load;
  logic               beat_last;
  logic               op_wr;
  logic [SRAM_DW-1:0] wdata_hi;
  logic [IW-1:0]      idx;

  assign req = mem.wr_en | mem.rd_en;

  // Word index relative to the SRAM window; out-of-range addresses wrap.
  assign idx = IW'((mem.address - 32'(ADDR_BASE)) >> 2);

  beat_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_beat_timer (
    .clk  (clk),
    .rst  (rst),
    .load (beat_load),
    .last (beat_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and beat timer reload; each beat starts with a reload.
  always_comb begin
    state_nxt = state;
    beat_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_LOW;
          beat_load = 1'b1;
        end
      end
      S_LOW: begin
        if (beat_last) begin
          state_nxt = S_HIGH;
          beat_load = 1'b1;
        end
      end
      S_HIGH: begin
        if (beat_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pipeline may advance when idle with nothing asked, or as the access completes.
  assign mem.ready = (state == S_IDLE) ? ~req : (state == S_DONE);

  // SRAM pad drive and read capture; pad outputs change only at beat boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr         <= 1'b0;
      wdata_hi      <= '0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_we_n     <= 1'b1;
      mem.read_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            // Write wins when both requests are raised together.
            op_wr     <= mem.wr_en;
            wdata_hi  <= mem.write_data[31:16];
            sram_addr <= {idx, 1'b0};
            if (mem.wr_en) begin
              sram_dq_out <= mem.write_data[15:0];
              sram_dq_oe  <= 1'b1;
              sram_we_n   <= 1'b0;
            end else begin
              sram_dq_oe  <= 1'b0;
              sram_we_n   <= 1'b1;
            end
          end
        end
        S_LOW: begin
          if (beat_last) begin
            sram_addr[0] <= 1'b1;
            if (op_wr) begin
              sram_dq_out <= wdata_hi;
            end else begin
              mem.read_data[15:0] <= sram_dq_in;
            end
          end
        end
        S_HIGH: begin
          if (beat_last) begin
            if (!op_wr) begin
              mem.read_data[31:16] <= sram_dq_in;
            end
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_MEM_CTRL_STATS_EN
  logic [31:0] reads_q, writes_q, stall_q;

  // Completed-op counters bump on entry to DONE; stall counts the LOW/HIGH
  // cycles the controller owns (the IDLE cycle presenting the request is not counted).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reads_q  <= '0;
      writes_q <= '0;
      stall_q  <= '0;
    end else begin
      if (state == S_HIGH && beat_last) begin
        if (op_wr) begin
          writes_q <= writes_q + 32'd1;
        end else begin
          reads_q <= reads_q + 32'd1;
        end
      end
      if (state == S_LOW || state == S_HIGH) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_stall  = stall_q;
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances with SRAM models.
// Latency: n/a.
// Backpressure: requests held until ready, as the MEM stage does.
module tb_sram_mem_ctrl;

  localparam int BEAT2 = 3;  // WAIT_CYCLES+1 for the main instance

  logic clk;
  logic rst_n;

  sram_mem_ctrl_if m2 ();
  sram_mem_ctrl_if m0 ();

  logic [17:0] addr2, addr0;
  logic [15:0] dq_out2, dq_out0, dq_in2, dq_in0;
  logic        oe2, oe0, we_n2, we_n0;
  logic [31:0] st_r2, st_w2, st_s2, st_r0, st_w0, st_s0;

  sram_mem_ctrl #(.WAIT_CYCLES(2), .ADDR_BASE(1024), .SRAM_AW(18)) dut2 (
    .clk(clk), .rst(rst_n), .mem(m2),
    .sram_addr(addr2), .sram_dq_out(dq_out2), .sram_dq_in(dq_in2),
    .sram_dq_oe(oe2), .sram_we_n(we_n2),
    .stat_reads(st_r2), .stat_writes(st_w2), .stat_stall(st_s2)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(0), .ADDR_BASE(1024), .SRAM_AW(18)) dut0 (
    .clk(clk), .rst(rst_n), .mem(m0),
    .sram_addr(addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
    .sram_dq_oe(oe0), .sram_we_n(we_n0),
    .stat_reads(st_r0), .stat_writes(st_w0), .stat_stall(st_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: write on the rising edge while we_n is low, asynchronous read.
  logic [15:0] sram2 [0:255];
  logic [15:0] sram0 [0:255];
  logic        preload;

  always @(posedge clk or posedge preload) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        sram2[i] = 16'h0;
        sram0[i] = 16'h0;
      end
      sram2[4] = 16'h1234;
      sram2[5] = 16'hABCD;
    end else begin
      if (!we_n2) sram2[addr2[7:0]] = dq_out2;
      if (!we_n0) sram0[addr0[7:0]] = dq_out0;
    end
  end

  assign dq_in2 = sram2[addr2[7:0]];
  assign dq_in0 = sram0[addr0[7:0]];

  int n_run;
  int n_fail;
  logic [31:0] sb_q [$];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_hw;
    logic [31:0] exp_rdata;
    bit          scramble;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance, checked cycle by cycle.
  // Called at a falling edge; returns at the falling edge inside DONE with the request still held.
  task automatic do_txn(input vec_t v, input bit after_done);
    bit          is_wr;
    bit          hi;
    logic [31:0] exp_q;
    is_wr = v.wr;
    m2.wr_en      = v.wr;
    m2.rd_en      = v.rd;
    m2.address    = v.addr;
    m2.write_data = v.wdata;
    sb_q.push_back(v.exp_rdata);
    #1;
    if (after_done) begin
      chk1("ready_in_done_overlap", m2.ready, 1'b1);
      @(negedge clk);
    end
    chk1("ready_idle_req", m2.ready, 1'b0);
    for (int c = 1; c <= 2*BEAT2 + 1; c++) begin
      @(negedge clk);
      if (v.scramble && c == 2) begin
        m2.address    = v.addr ^ 32'h0000_0FF0;
        m2.write_data = ~v.wdata;
      end
      if (v.scramble && c == 2*BEAT2) begin
        m2.address    = v.addr;
        m2.write_data = v.wdata;
      end
      hi = (c > BEAT2);
      if (c <= 2*BEAT2) begin
        chk1("ready_busy", m2.ready, 1'b0);
        chk("sram_addr", {14'd0, addr2}, {14'd0, v.exp_hw | {17'd0, hi}});
        chk1("we_n", we_n2, !is_wr);
        chk1("dq_oe", oe2, is_wr);
        if (is_wr)
          chk("dq_out", {16'd0, dq_out2}, {16'd0, hi ? v.wdata[31:16] : v.wdata[15:0]});
        if (!is_wr && hi)
          chk("rd_low_half_early", {16'd0, m2.read_data[15:0]}, {16'd0, v.exp_rdata[15:0]});
      end else begin
        chk1("ready_done", m2.ready, 1'b1);
        chk1("we_n_done", we_n2, 1'b1);
        chk1("dq_oe_done", oe2, 1'b0);
        if (sb_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL scoreboard_empty: got none expected one entry");
        end else begin
          exp_q = sb_q.pop_front();
          chk("read_data", m2.read_data, exp_q);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    preload = 1'b0;
    rst_n   = 1'b0;
    m2.wr_en = 1'b0; m2.rd_en = 1'b0; m2.address = '0; m2.write_data = '0;
    m0.wr_en = 1'b0; m0.rd_en = 1'b0; m0.address = '0; m0.write_data = '0;

    //              wr rd addr           wdata          hw         rdata          scr
    vecs[0] = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 18'd2,     32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'd1032,   32'h0,        18'd4,     32'hABCD1234, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'd1028,   32'h0,        18'd2,     32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'd1024,   32'h5A5AA5A5, 18'd0,     32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'd1024,   32'h0,        18'd0,     32'h5A5AA5A5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'd1100,   32'h0BADF00D, 18'd38,    32'h5A5AA5A5, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'd1100,   32'h0,        18'd38,    32'h0BADF00D, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 32'd525320, 32'h0,        18'd4,     32'hABCD1234, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'd1020,   32'h13579BDF, 18'h3FFFE, 32'hABCD1234, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 32'd1020,   32'h0,        18'h3FFFE, 32'h13579BDF, 1'b0};

    #1 preload = 1'b1;
    #1 preload = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_read_data", m2.read_data, 32'h0);
    chk("rst_sram_addr", {14'd0, addr2}, 32'h0);
    chk("rst_dq_out", {16'd0, dq_out2}, 32'h0);
    chk1("rst_dq_oe", oe2, 1'b0);
    chk1("rst_we_n", we_n2, 1'b1);
    chk1("rst_ready", m2.ready, 1'b1);
    chk1("rst_ready_w0", m0.ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of back-to-back accesses on the WAIT_CYCLES=2 instance
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i], i > 0);
    end
    m2.wr_en = 1'b0;
    m2.rd_en = 1'b0;
    @(negedge clk);
    chk1("ready_idle_after_table", m2.ready, 1'b1);

    // WAIT_CYCLES=0: one-cycle beats, DONE in cycle 3, then back-to-back read
    m0.wr_en = 1'b1; m0.rd_en = 1'b0; m0.address = 32'd1028; m0.write_data = 32'hCAFEF00D;
    #1 chk1("w0_ready_req", m0.ready, 1'b0);
    @(negedge clk);
    chk("w0_lo_addr", {14'd0, addr0}, 32'd2);
    chk1("w0_lo_we_n", we_n0, 1'b0);
    chk("w0_lo_dq", {16'd0, dq_out0}, 32'h0000F00D);
    @(negedge clk);
    chk("w0_hi_addr", {14'd0, addr0}, 32'd3);
    chk("w0_hi_dq", {16'd0, dq_out0}, 32'h0000CAFE);
    chk1("w0_hi_ready", m0.ready, 1'b0);
    @(negedge clk);
    chk1("w0_done_ready", m0.ready, 1'b1);
    chk1("w0_done_we_n", we_n0, 1'b1);
    m0.wr_en = 1'b0; m0.rd_en = 1'b1;
    @(negedge clk);
    chk1("w0_rd_idle_ready", m0.ready, 1'b0);
    @(negedge clk);
    chk("w0_rd_lo_addr", {14'd0, addr0}, 32'd2);
    chk1("w0_rd_oe", oe0, 1'b0);
    @(negedge clk);
    chk("w0_rd_hi_addr", {14'd0, addr0}, 32'd3);
    chk("w0_rd_low_half", {16'd0, m0.read_data[15:0]}, 32'h0000F00D);
    @(negedge clk);
    chk1("w0_rd_done_ready", m0.ready, 1'b1);
    chk("w0_rd_data", m0.read_data, 32'hCAFEF00D);
    m0.rd_en = 1'b0;
    @(negedge clk);

    // Asynchronous reset during the HIGH beat of a store
    m2.wr_en = 1'b1; m2.rd_en = 1'b0; m2.address = 32'd1028; m2.write_data = 32'h11112222;
    repeat (4) @(negedge clk);
    chk("arst_pre_addr", {14'd0, addr2}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_we_n", we_n2, 1'b1);
    chk1("arst_oe", oe2, 1'b0);
    chk("arst_addr", {14'd0, addr2}, 32'h0);
    chk("arst_read_data", m2.read_data, 32'h0);
    chk1("arst_ready_idle_req", m2.ready, 1'b0);
    chk("arst_stat_writes", st_w2, 32'h0);
    chk("arst_stat_stall", st_s2, 32'h0);
    m2.wr_en = 1'b0;
    #1 chk1("arst_ready_idle", m2.ready, 1'b1);
    chk("partial_low_half", {16'd0, sram2[2]}, 32'h00002222);
    chk("partial_high_half", {16'd0, sram2[3]}, 32'h0000DEAD);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requests at the base address: write wins, read_data untouched
    do_txn('{1'b1, 1'b1, 32'd1024, 32'h2468ACE0, 18'd0, 32'h0, 1'b0}, 1'b0);
`ifdef SRAM_MEM_CTRL_STATS_EN
    chk("stat_writes", st_w2, 32'd1);
    chk("stat_reads", st_r2, 32'd0);
    chk("stat_stall", st_s2, 32'd6);
`else
    chk("stat_writes_tied", st_w2, 32'd0);
    chk("stat_reads_tied", st_r2, 32'd0);
    chk("stat_stall_tied", st_s2, 32'd0);
`endif
    chk("both_set_hw0", {16'd0, sram2[0]}, 32'h0000ACE0);
    chk("both_set_hw1", {16'd0, sram2[1]}, 32'h00002468);
    do_txn('{1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEAD2222, 1'b0}, 1'b1);
    m2.wr_en = 1'b0;
    m2.rd_en = 1'b0;
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
